// File: rtl/irq_req_latch_pkg.sv
// Shared definitions for the interrupt request front-end.
//   NSRC     : number of request sources
//   IDW      : width of a source ID
//   state_t  : offer FSM state (IDLE / OFFER)
//   id_onehot: expands a source ID into its one-hot bit vector
package irq_req_latch_pkg;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [NSRC-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [NSRC-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_req_latch_pri_en.sv
// pri_en: 8-input priority encoder.
//   i     in  NSRC  request vector
//   out   out IDW   index of the highest set bit (0 when none set)
//   valid out 1     at least one bit of i is set
// Bit NSRC-1 has the highest priority.
module pri_en
  import irq_req_latch_pkg::*;
(
  input  logic [NSRC-1:0] i,
  output logic [IDW-1:0]  out,
  output logic            valid
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    for (int b = 0; b < NSRC; b++) begin
      if (i[b]) begin
        out   = IDW'(b);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_req_latch.sv
// irq_req_latch: interrupt request front-end.
// Detects rising edges on the request lines, latches them as pending,
// and offers the highest-priority unmasked pending source ID downstream.
//   clk       in  1  clock, rising edge
//   rst_n     in  1  synchronous active-low reset
//   req       in  8  raw request lines (0->1 between samples = one event)
//   mask      in  8  1 = source may be offered; masked sources still latch
//   irq_id    out 3  offered source ID (7 = highest priority)
//   irq_valid out 1  irq_id holds a live offer
//   irq_ready in  1  consumer accepts the offer
//   pend      out 8  pending register
//   ovr       out 8  sticky overrun flags
//   ovr_clr   in  1  clears all overrun flags
//
// Handshake: a transfer happens at a rising edge where irq_valid and
// irq_ready are both 1. While irq_valid is 1, irq_id is frozen until that
// transfer; irq_valid never depends combinationally on irq_ready.
module irq_req_latch
  import irq_req_latch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] mask,
  output logic [IDW-1:0]  irq_id,
  output logic            irq_valid,
  input  logic            irq_ready,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] ovr,
  input  logic            ovr_clr
);

  state_t          state_q;
  state_t          state_d;
  logic [NSRC-1:0] req_q;
  logic [NSRC-1:0] new_ev;
  logic [NSRC-1:0] elig;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            load;
  logic [NSRC-1:0] load_clr;

  assign new_ev   = req & ~req_q;
  assign elig     = pend & mask;
  assign load_clr = load ? id_onehot(win_id) : '0;

  pri_en u_pri_en (
    .i     (elig),
    .out   (win_id),
    .valid (win_valid)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and load decision. A load happens whenever the offer
  // slot is free (IDLE) or being vacated by a handshake this edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (irq_ready) begin
          if (win_valid) load    = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a decode of the state register only.
  always_comb begin
    irq_valid = (state_q == OFFER);
  end

  // Datapath: edge history, offered ID, pending and overrun registers.
  // A new edge on a bit being cleared this edge re-arms it (set wins) and
  // is not an overrun; an overrun also beats a simultaneous ovr_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= '0;
      irq_id <= '0;
      pend   <= '0;
      ovr    <= '0;
    end else begin
      req_q <= req;
      if (load) irq_id <= win_id;
      pend <= (pend & ~load_clr) | new_ev;
      ovr  <= (ovr_clr ? '0 : ovr) | (new_ev & pend & ~load_clr);
    end
  end

endmodule

// File: tb/tb_irq_req_latch.sv
module tb_irq_req_latch;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic [2:0] irq_id;
  logic       irq_valid;
  logic       irq_ready;
  logic [7:0] pend;
  logic [7:0] ovr;
  logic       ovr_clr;

  int vectors;
  int miscompares;

  // Reference model state (source-level view: per-bit pending/overrun
  // flags, an offer slot, and the previous request sample).
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic [7:0] m_ovr;
  logic       m_valid;
  logic [2:0] m_id;

  irq_req_latch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .irq_id    (irq_id),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .pend      (pend),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge of the reference: the offer slot is refilled with the
  // highest eligible pending source when empty or just accepted; edges
  // arriving on a still-pending bit merge and flag an overrun.
  task automatic model_step();
    logic [7:0] edges;
    logic [7:0] taken;
    int         found;
    edges = req & ~m_prev;
    taken = 8'h00;
    if (!rst_n) begin
      m_prev = 8'h00; m_pend = 8'h00; m_ovr = 8'h00;
      m_valid = 1'b0; m_id = 3'd0;
      return;
    end
    if (!m_valid || irq_ready) begin
      found = 0;
      for (int b = 7; b >= 0; b--) begin
        if (found == 0 && m_pend[b] && mask[b]) begin
          found    = 1;
          m_id     = 3'(b);
          taken[b] = 1'b1;
        end
      end
      m_valid = (found != 0);
    end
    if (ovr_clr) m_ovr = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (edges[b] && m_pend[b] && !taken[b]) m_ovr[b] = 1'b1;
      m_pend[b] = (m_pend[b] && !taken[b]) || edges[b];
    end
    m_prev = req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pend", pend, m_pend);
    check("ovr", ovr, m_ovr);
    check("irq_valid", {7'd0, irq_valid}, {7'd0, m_valid});
    check("irq_id", {5'd0, irq_id}, {5'd0, m_id});
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_prev = 8'h00; m_pend = 8'h00; m_ovr = 8'h00; m_valid = 1'b0; m_id = 3'd0;
    rst_n = 1'b0; req = 8'hFF; mask = 8'hFF; irq_ready = 1'b0; ovr_clr = 1'b0;

    // 1. Reset with requests high, then release
    tick(); tick();
    check("rst_pend", pend, 8'h00);
    check("rst_valid", {7'd0, irq_valid}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("t1_pend_ff", pend, 8'hFF);
    tick();
    check("t1_valid", {7'd0, irq_valid}, 8'h01);
    check("t1_id7", {5'd0, irq_id}, 8'h07);
    check("t1_pend_7f", pend, 8'h7F);
    irq_ready = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    req = 8'h00;
    tick();
    check("t1_drained", {7'd0, irq_valid}, 8'h00);

    // 2. Priority drain
    req = 8'hA4; tick();
    req = 8'h00; tick();
    check("t2_id7", {5'd0, irq_id}, 8'h07);
    tick();
    check("t2_id5", {5'd0, irq_id}, 8'h05);
    tick();
    check("t2_id2", {5'd0, irq_id}, 8'h02);
    tick();
    check("t2_idle", {7'd0, irq_valid}, 8'h00);
    check("t2_pend0", pend, 8'h00);

    // 3. Hold under backpressure
    irq_ready = 1'b0;
    req = 8'h04; tick();
    req = 8'h00; tick();
    req = 8'h40; tick();
    req = 8'h00; tick();
    check("t3_hold2", {5'd0, irq_id}, 8'h02);
    irq_ready = 1'b1; tick();
    check("t3_next6", {5'd0, irq_id}, 8'h06);
    tick();

    // 4. Masking
    mask = 8'h0F;
    req = 8'h82; tick();
    req = 8'h00; tick();
    check("t4_id1", {5'd0, irq_id}, 8'h01);
    tick();
    check("t4_pend7", pend, 8'h80);
    irq_ready = 1'b0;
    mask = 8'hFF; tick(); tick();
    check("t4_id7", {5'd0, irq_id}, 8'h07);
    check("t4_valid7", {7'd0, irq_valid}, 8'h01);
    irq_ready = 1'b1; tick(); tick();

    // 5. Overrun / merge
    mask = 8'h00;
    req = 8'h08; tick();
    req = 8'h00; tick();
    req = 8'h08; tick();
    req = 8'h00; tick();
    check("t5_pend3", pend, 8'h08);
    check("t5_ovr3", ovr, 8'h08);
    ovr_clr = 1'b1; tick();
    ovr_clr = 1'b0;
    check("t5_ovr_clr", ovr, 8'h00);
    mask = 8'h08; req = 8'h08; tick();
    check("t5_rearm_pend", pend, 8'h08);
    check("t5_rearm_ovr", ovr, 8'h00);
    req = 8'h00; tick(); tick(); tick();

    // 6. Reset mid-offer
    mask = 8'hFF; irq_ready = 1'b0;
    req = 8'h31; tick();
    req = 8'h00; mask = 8'h01; tick();
    check("t6_pend30", pend, 8'h30);
    check("t6_valid", {7'd0, irq_valid}, 8'h01);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("t6_rst_valid", {7'd0, irq_valid}, 8'h00);
    check("t6_rst_pend", pend, 8'h00);
    check("t6_rst_ovr", ovr, 8'h00);
    mask = 8'hFF;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req       = 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      irq_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
